// File: rtl/dp_data_ram_pkg.sv
// rtl/dp_data_ram_pkg.sv - shared types and constants for the dual-port data RAM
package dp_data_ram_pkg;

    localparam int LANE_W = 8;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

endpackage

// File: rtl/dp_data_ram_clr_fsm.sv
// rtl/dp_data_ram_clr_fsm.sv - zero-sweep sequencer: state, sweep counter and busy
module dp_data_ram_clr_fsm
    import dp_data_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clr,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] clr_addr
);

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // The counter wraps to 0 on the last sweep word, so READY always starts from 0.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            CLEAR: begin
                cnt_nxt = cnt + 1'b1;
                if (cnt == {ADDR_WIDTH{1'b1}}) begin
                    state_nxt = READY;
                end
            end
            READY: begin
                if (clr) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end
            end
            default: state_nxt = CLEAR;
        endcase
    end

    assign busy     = (state == CLEAR);
    assign clr_addr = cnt;

endmodule

// File: rtl/dp_data_ram.sv
// rtl/dp_data_ram.sv - byte-writable 1W/1R RAM with zero sweep; DP_DATA_RAM_PARITY_EN adds per-byte parity
module dp_data_ram
    import dp_data_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int RDW_NEW    = 0
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         clr,
    input  logic                         a_we,
    input  logic [DATA_WIDTH/LANE_W-1:0] a_be,
    input  logic [ADDR_WIDTH-1:0]        a_addr,
    input  logic [DATA_WIDTH-1:0]        a_data,
    input  logic                         b_re,
    input  logic [ADDR_WIDTH-1:0]        b_addr,
    output logic [DATA_WIDTH-1:0]        b_q,
    output logic                         b_valid,
    output logic                         busy
`ifdef DP_DATA_RAM_PARITY_EN
   ,output logic                         b_perr
`endif
);

    localparam int NB    = DATA_WIDTH / LANE_W;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  wr_en;
    logic                  rd_en;
    logic                  same_addr;
    logic [DATA_WIDTH-1:0] rd_sel;

    dp_data_ram_clr_fsm #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clr_fsm (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (clr),
        .busy     (busy),
        .clr_addr (clr_addr)
    );

    assign wr_en     = a_we && !busy;
    assign rd_en     = b_re && !busy;
    assign same_addr = wr_en && (a_addr == b_addr);

    // The array itself is never reset; the sweep is what zeroes it.
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[clr_addr] <= '0;
        end else if (a_we) begin
            for (int i = 0; i < NB; i++) begin
                if (a_be[i]) begin
                    mem[a_addr][i*LANE_W +: LANE_W] <= a_data[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    always_comb begin
        rd_sel = mem[b_addr];
        if (RDW_NEW != 0) begin
            for (int i = 0; i < NB; i++) begin
                if (same_addr && a_be[i]) begin
                    rd_sel[i*LANE_W +: LANE_W] = a_data[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            b_q     <= '0;
            b_valid <= 1'b0;
        end else if (rd_en) begin
            b_q     <= rd_sel;
            b_valid <= 1'b1;
        end else begin
            b_valid <= 1'b0;
        end
    end

`ifdef DP_DATA_RAM_PARITY_EN
    logic [NB-1:0] par_mem [DEPTH];
    logic [NB-1:0] par_sel;
    logic [NB-1:0] lane_err;

    // Even parity: the stored bit makes byte plus parity XOR to zero.
    always_ff @(posedge clk) begin
        if (busy) begin
            par_mem[clr_addr] <= '0;
        end else if (a_we) begin
            for (int i = 0; i < NB; i++) begin
                if (a_be[i]) begin
                    par_mem[a_addr][i] <= ^a_data[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    always_comb begin
        par_sel = par_mem[b_addr];
        if (RDW_NEW != 0) begin
            for (int i = 0; i < NB; i++) begin
                if (same_addr && a_be[i]) begin
                    par_sel[i] = ^a_data[i*LANE_W +: LANE_W];
                end
            end
        end
        lane_err = '0;
        for (int i = 0; i < NB; i++) begin
            lane_err[i] = (^rd_sel[i*LANE_W +: LANE_W]) ^ par_sel[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            b_perr <= 1'b0;
        end else begin
            b_perr <= rd_en && (|lane_err);
        end
    end
`endif

endmodule

// File: tb/tb_dp_data_ram.sv
// tb/tb_dp_data_ram.sv - self-checking bench for dp_data_ram (old- and new-data read-during-write instances)
module tb_dp_data_ram;

    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          clr = 1'b0;
    logic          a_we = 1'b0;
    logic [1:0]    a_be = '0;
    logic [AW-1:0] a_addr = '0;
    logic [DW-1:0] a_data = '0;
    logic          b_re = 1'b0;
    logic [AW-1:0] b_addr = '0;

    logic [DW-1:0] q0, q1;
    logic          v0, v1, busy0, busy1;
`ifdef DP_DATA_RAM_PARITY_EN
    logic          perr0, perr1;
`endif

    int ntests = 0;
    int nfail  = 0;

    always #5 clk = ~clk;

    dp_data_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RDW_NEW(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .clr(clr), .a_we(a_we), .a_be(a_be),
        .a_addr(a_addr), .a_data(a_data), .b_re(b_re), .b_addr(b_addr),
        .b_q(q0), .b_valid(v0), .busy(busy0)
`ifdef DP_DATA_RAM_PARITY_EN
       ,.b_perr(perr0)
`endif
    );

    dp_data_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RDW_NEW(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .clr(clr), .a_we(a_we), .a_be(a_be),
        .a_addr(a_addr), .a_data(a_data), .b_re(b_re), .b_addr(b_addr),
        .b_q(q1), .b_valid(v1), .busy(busy1)
`ifdef DP_DATA_RAM_PARITY_EN
       ,.b_perr(perr1)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                            input logic [1:0] be);
        logic [DW-1:0] r;
        r = old;
        if (be[0]) r[7:0]  = d[7:0];
        if (be[1]) r[15:8] = d[15:8];
        return r;
    endfunction

    // Reference: array of words, a countdown of sweep cycles, last read results.
    logic [DW-1:0] m_mem [DEPTH];
    int            clear_left = DEPTH;
    logic [DW-1:0] e_q0 = '0, e_q1 = '0, m_old;
    logic          e_v = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clear_left = DEPTH;
            e_q0 = '0;
            e_q1 = '0;
            e_v  = 1'b0;
        end else if (clear_left > 0) begin
            clear_left--;
            e_v = 1'b0;
            if (clear_left == 0) begin
                for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
            end
        end else begin
            if (b_re) begin
                m_old = m_mem[b_addr];
                e_q0  = m_old;
                e_q1  = (a_we && a_addr == b_addr) ? merge(m_old, a_data, a_be) : m_old;
                e_v   = 1'b1;
            end else begin
                e_v = 1'b0;
            end
            if (a_we) m_mem[a_addr] = merge(m_mem[a_addr], a_data, a_be);
            if (clr)  clear_left = DEPTH;
        end
    end

    always @(negedge clk) begin
        chk("busy0", busy0, clear_left > 0);
        chk("busy1", busy1, clear_left > 0);
        chk("valid0", v0, e_v);
        chk("valid1", v1, e_v);
        chk("q0", q0, e_q0);
        chk("q1", q1, e_q1);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] be);
        a_we = 1'b1; a_addr = a; a_data = d; a_be = be;
        tick();
        a_we = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a);
        b_re = 1'b1; b_addr = a;
        tick();
        b_re = 1'b0;
    endtask

    task automatic count_busy(input string name);
        int cnt;
        cnt = 0;
        while (busy0 && cnt < 100) begin
            tick();
            cnt++;
        end
        chk(name, cnt, 16);
    endtask

    initial begin
        int cnt;
        tick(); tick(); tick();
        chk("reset_q", q0, 16'h0000);
        chk("reset_busy", busy0, 1'b1);
        reset_n = 1'b1;
        count_busy("busy_after_reset");

        for (int i = 0; i < DEPTH; i++) begin
            rd(AW'(i));
            chk("sweep_zero", q0, 16'h0000);
        end

        wr(4'd3, 16'h1111, 2'b11);
        wr(4'd3, 16'hA5C3, 2'b01);
        rd(4'd3);
        chk("byte_lane_q", q0, 16'h11C3);
        chk("byte_lane_valid", v0, 1'b1);
        wr(4'd4, 16'hABCD, 2'b10);
        rd(4'd4);
        chk("upper_lane_q", q0, 16'hAB00);
        tick();
        chk("hold_q", q0, 16'hAB00);
        chk("hold_valid", v0, 1'b0);

        wr(4'd7, 16'h00FF, 2'b11);
        a_we = 1'b1; a_addr = 4'd7; a_data = 16'h1234; a_be = 2'b11;
        b_re = 1'b1; b_addr = 4'd7;
        tick();
        a_we = 1'b0; b_re = 1'b0;
        chk("rdw_old", q0, 16'h00FF);
        chk("rdw_new", q1, 16'h1234);
        a_we = 1'b1; a_addr = 4'd7; a_data = 16'hEE99; a_be = 2'b10;
        b_re = 1'b1; b_addr = 4'd7;
        tick();
        a_we = 1'b0; b_re = 1'b0;
        chk("rdw_new_partial", q1, 16'hEE34);
        rd(4'd7);
        chk("after_rdw", q0, 16'hEE34);

        clr = 1'b1;
        tick();
        clr = 1'b0;
        a_we = 1'b1; a_addr = 4'd5; a_data = 16'hFFFF; a_be = 2'b11;
        b_re = 1'b1; b_addr = 4'd5;
        cnt = 0;
        while (busy0 && cnt < 100) begin
            chk("clr_valid", v0, 1'b0);
            tick();
            cnt++;
        end
        a_we = 1'b0; b_re = 1'b0;
        chk("busy_after_clr", cnt, 16);
        rd(4'd5);
        chk("dropped_write", q0, 16'h0000);
        for (int i = 0; i < DEPTH; i++) rd(AW'(i));

        wr(4'd1, 16'hBEEF, 2'b11);
        rd(4'd1);
        chk("pre_reset_q", q0, 16'hBEEF);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        #1 reset_n = 1'b0;
        #1;
        chk("rst_q", q0, 16'h0000);
        chk("rst_valid", v0, 1'b0);
        chk("rst_busy", busy0, 1'b1);
        tick();
        reset_n = 1'b1;
        count_busy("busy_after_midreset");
        rd(4'd1);
        chk("restart_zero", q0, 16'h0000);
        for (int i = 0; i < DEPTH; i++) rd(AW'(i));

`ifdef DP_DATA_RAM_PARITY_EN
        wr(4'd2, 16'h5A01, 2'b11);
        rd(4'd2);
        chk("perr_clean", perr0, 1'b0);
        dut0.par_mem[2][0] = ~dut0.par_mem[2][0];
        rd(4'd2);
        chk("perr_flip", perr0, 1'b1);
        chk("perr_flip_valid", v0, 1'b1);
        rd(4'd3);
        chk("perr_other", perr0, 1'b0);
`endif

        tick();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/dp_data_ram.md
DP_DATA_RAM -- requirements
Module: dp_data_ram

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, data word width; it SHALL be a multiple of 8.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 8, address width; depth is 2**ADDR_WIDTH.
REQ-003 The block SHALL have parameter RDW_NEW, default 0, read-during-write result on port B: 0 = old data, 1 = new (forwarded) data.
REQ-004 The block SHALL have these ports:
- clk  in  1  system clock, all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- clr  in  1  single-cycle request to zero the whole array.
- a_we  in  1  port A write enable.
- a_be  in  DATA_WIDTH/8  port A byte enables.
- a_addr  in  ADDR_WIDTH  port A address.
- a_data  in  DATA_WIDTH  port A write data.
- b_re  in  1  port B read enable.
- b_addr  in  ADDR_WIDTH  port B address.
- b_q  out  DATA_WIDTH  port B read data.
- b_valid  out  1  b_q holds data for a read accepted in the previous cycle.
- busy  out  1  clear in progress; requests ignored.

Function
REQ-005 FSM states SHALL be CLEAR and READY; reset enters CLEAR with the clear counter at 0.
REQ-006 In CLEAR, one word per cycle SHALL be written with zero at the counter address, counter +1; after address 2**ADDR_WIDTH-1 is written, the next state SHALL be READY.
REQ-007 busy SHALL be 1 exactly while in CLEAR; a_we and b_re SHALL be ignored while busy, and b_valid SHALL stay 0.
REQ-008 clr sampled high in READY SHALL enter CLEAR on the next edge with the counter at 0; clr in CLEAR SHALL be ignored.
REQ-009 In READY, a_we=1 SHALL write byte lane i of a_data to a_addr only where a_be[i]=1; other lanes SHALL keep their contents.
REQ-010 In READY, b_re=1 at edge N SHALL load b_q at edge N with the word at b_addr and set b_valid=1 (one-cycle latency); b_re=0 SHALL clear b_valid and hold b_q.
REQ-011 Same-edge write to a_addr==b_addr with b_re=1: RDW_NEW=0 SHALL return the pre-write word; RDW_NEW=1 SHALL return per lane the new byte where a_be set, else the old byte.
REQ-012 Address arithmetic SHALL be unsigned ADDR_WIDTH bits; the clear counter SHALL wrap cleanly to 0 on exit.

Reset
REQ-013 reset_n low SHALL asynchronously force b_q=0, b_valid=0, busy=1, state CLEAR, counter 0; array contents SHALL NOT be reset directly (zeroed by the CLEAR sweep).
REQ-014 reset_n asserted mid-clear SHALL restart the sweep from address 0 after release.

Configuration
REQ-015 With DP_DATA_RAM_PARITY_EN defined, each byte SHALL be stored with an even-parity bit (written with the byte; zero-sweep stores parity 0), and output b_perr (1 bit) SHALL be 1 together with b_valid when any enabled read byte fails its check; reset value 0.
REQ-016 Without DP_DATA_RAM_PARITY_EN, no parity storage and no b_perr port SHALL exist.

Structure
REQ-017 Package dp_data_ram_pkg SHALL hold the FSM state type and lane-width constant (8).
REQ-018 Sub-module dp_data_ram_clr_fsm SHALL own the state register, counter and busy; the array and port logic SHALL stay in dp_data_ram.

Verification
REQ-019 Reset release, DATA_WIDTH=16, ADDR_WIDTH=4 -> busy=1 for exactly 16 cycles, then reads of all 16 addresses return 0x0000.
REQ-020 Write 0xA5C3 to addr 3, a_be=2'b01, over 0x1111 -> read addr 3 next cycle gives b_q=0x11C3, b_valid=1.
REQ-021 Word 0x00FF at addr 7; same-edge write 0x1234 a_be=2'b11 and read addr 7 -> RDW_NEW=0 gives 0x00FF, RDW_NEW=1 gives 0x1234.
REQ-022 clr pulse in READY, then a_we and b_re during sweep -> writes dropped, b_valid=0, all words 0 after busy falls.
REQ-023 reset_n pulsed low at sweep address 9 -> b_q=0, b_valid=0 immediately; sweep restarts at 0, busy lasts full 16 cycles.
REQ-024 With DP_DATA_RAM_PARITY_EN, force one stored bit flip at addr 2 then read -> b_perr=1 with b_valid=1; clean address -> b_perr=0.
